// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transfer sequencer.
// Used by spi_xfer_fsm and spi_bit_counter.
package spi_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    RW    = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic int cnt_w(input int a, input int d);
    int m;
    m = (a > d) ? a : d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Serial bit counter with synchronous clear and a terminal-count flag
// that reports when the current enable would reach i_term.
module spi_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_last
);

  logic [W-1:0] r_cnt;
  logic [W:0]   w_nxt;

  assign w_nxt  = {1'b0, r_cnt} + (W+1)'(1);
  assign o_last = (w_nxt == {1'b0, i_term});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_nxt[W-1:0];
    end
  end

endmodule

// File: rtl/spi_xfer_fsm.sv
// SPI slave transfer sequencer: address, rw and data phases on sclk strobes.
// Define SPI_BURST_EN for auto-incrementing multi-word bursts.
module spi_xfer_fsm
  import spi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_edge,
  input  logic cs,
  input  logic rw,
  output logic miso_buff,
  output logic dm_we,
  output logic addr_we,
  output logic sr_we,
  output logic addr_inc,
  output logic xfer_done
);

  localparam int CW = cnt_w(ADDR_W, DATA_W);
  localparam logic [CW-1:0] ATERM = CW'(ADDR_W);
  localparam logic [CW-1:0] DTERM = CW'(DATA_W);

  state_t r_state;
  state_t w_state_nxt;

  logic r_miso, r_dm_we, r_addr_we, r_sr_we, r_addr_inc, r_done;
  logic w_miso, w_dm_we, w_addr_we, w_sr_we, w_addr_inc, w_done;

  logic r_pend_inc, r_pend_ld1, r_pend_ld2;
  logic w_pend_inc, w_pend_ld1, w_pend_ld2;

  logic          w_clr;
  logic          w_en;
  logic          w_last;
  logic [CW-1:0] w_term;

  spi_bit_counter #(
    .W(CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (w_en),
    .i_term(w_term),
    .o_last(w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_miso     <= 1'b0;
      r_dm_we    <= 1'b0;
      r_addr_we  <= 1'b0;
      r_sr_we    <= 1'b0;
      r_addr_inc <= 1'b0;
      r_done     <= 1'b0;
      r_pend_inc <= 1'b0;
      r_pend_ld1 <= 1'b0;
      r_pend_ld2 <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_miso     <= w_miso;
      r_dm_we    <= w_dm_we;
      r_addr_we  <= w_addr_we;
      r_sr_we    <= w_sr_we;
      r_addr_inc <= w_addr_inc;
      r_done     <= w_done;
      r_pend_inc <= w_pend_inc;
      r_pend_ld1 <= w_pend_ld1;
      r_pend_ld2 <= w_pend_ld2;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    w_term      = DTERM;
    w_miso      = 1'b0;
    w_dm_we     = 1'b0;
    w_addr_we   = 1'b0;
    w_sr_we     = 1'b0;
    w_addr_inc  = 1'b0;
    w_done      = 1'b0;
    w_pend_inc  = 1'b0;
    w_pend_ld1  = 1'b0;
    w_pend_ld2  = 1'b0;
    if (cs) begin
      w_state_nxt = IDLE;
      w_clr       = 1'b1;
    end else begin
      // burst follow-ups: bump address, then reload once memory has it
      w_addr_inc = r_pend_inc;
      w_pend_ld2 = r_pend_ld1;
      w_sr_we    = r_pend_ld2;
      unique case (r_state)
        IDLE, ADDR: begin
          w_term = ATERM;
          if (sclk_edge) begin
            w_en        = 1'b1;
            w_state_nxt = ADDR;
            if (w_last) begin
              w_addr_we   = 1'b1;
              w_clr       = 1'b1;
              w_state_nxt = RW;
            end
          end
        end
        RW: begin
          if (sclk_edge) begin
            w_clr = 1'b1;
            if (rw) begin
              w_sr_we     = 1'b1;
              w_miso      = 1'b1;
              w_state_nxt = READ;
            end else begin
              w_state_nxt = WRITE;
            end
          end
        end
        READ: begin
          w_miso = 1'b1;
          if (sclk_edge) begin
            w_en = 1'b1;
            if (w_last) begin
              w_done = 1'b1;
              w_clr  = 1'b1;
`ifdef SPI_BURST_EN
              w_pend_inc = 1'b1;
              w_pend_ld1 = 1'b1;
`else
              w_miso      = 1'b0;
              w_state_nxt = DONE;
`endif
            end
          end
        end
        WRITE: begin
          if (sclk_edge) begin
            w_en = 1'b1;
            if (w_last) begin
              w_done  = 1'b1;
              w_dm_we = 1'b1;
              w_clr   = 1'b1;
`ifdef SPI_BURST_EN
              w_pend_inc = 1'b1;
`else
              w_state_nxt = DONE;
`endif
            end
          end
        end
        DONE: begin
          w_clr = 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
          w_clr       = 1'b1;
        end
      endcase
    end
  end

  assign miso_buff = r_miso;
  assign dm_we     = r_dm_we;
  assign addr_we   = r_addr_we;
  assign sr_we     = r_sr_we;
  assign addr_inc  = r_addr_inc;
  assign xfer_done = r_done;

endmodule
